// File: rtl/id_stage_param.sv
// rtl/id_stage_param.sv - MIPS decode stage: register file, immediate extension, pipeline output register
module id_stage_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int PCW      = 10,
    parameter int WB_PORTS = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              ip_instruction,
    input  logic [PCW-1:0]           ip_PC_plus_4,
    input  logic                     ip_valid,
    input  logic                     ip_stall,
    input  logic                     ip_hold,
    input  logic                     ip_flush,
    input  logic [WB_PORTS-1:0]      ip_wb_we,
    input  logic [5*WB_PORTS-1:0]    ip_wb_addr,
    input  logic [XLEN*WB_PORTS-1:0] ip_wb_data,
    output logic                     op_valid,
    output logic [5:0]               op_opcode,
    output logic [5:0]               op_function_opcode,
    output logic [PCW-1:0]           op_PC_plus_4,
    output logic [XLEN-1:0]          op_read_data_1,
    output logic [XLEN-1:0]          op_read_data_2,
    output logic [XLEN-1:0]          op_immediate,
    output logic [4:0]               op_dest_reg_R_type,
    output logic [4:0]               op_dest_reg_I_type,
    output logic [4:0]               op_dec_rs,
    output logic [4:0]               op_dec_rt
);

    localparam int IW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    // Returns {hit, data}; later ports override earlier ones so port 1 wins.
    function automatic logic [XLEN:0] wb_match(
        input logic [IW-1:0]              idx,
        input logic [WB_PORTS-1:0]        we,
        input logic [5*WB_PORTS-1:0]      addr,
        input logic [XLEN*WB_PORTS-1:0]   data
    );
        logic [XLEN:0] r;
        r = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (we[k] && idx != '0 && addr[5*k +: IW] == idx)
                r = {1'b1, data[XLEN*k +: XLEN]};
        end
        return r;
    endfunction

    logic [IW-1:0]   rs_idx, rt_idx, held_rs_idx, held_rt_idx;
    logic [XLEN:0]   rs_m, rt_m, held_rs_m, held_rt_m;
    logic [XLEN-1:0] rd1_new, rd2_new, imm_ext;
    logic [63:0]     imm_w;
    logic [5:0]      opcode;
    logic [15:0]     imm16;

    assign opcode      = ip_instruction[31:26];
    assign imm16       = ip_instruction[15:0];
    assign rs_idx      = ip_instruction[21 +: IW];
    assign rt_idx      = ip_instruction[16 +: IW];
    assign held_rs_idx = op_dec_rs[IW-1:0];
    assign held_rt_idx = op_dec_rt[IW-1:0];

    always_comb begin
        rs_m      = wb_match(rs_idx, ip_wb_we, ip_wb_addr, ip_wb_data);
        rt_m      = wb_match(rt_idx, ip_wb_we, ip_wb_addr, ip_wb_data);
        held_rs_m = wb_match(held_rs_idx, ip_wb_we, ip_wb_addr, ip_wb_data);
        held_rt_m = wb_match(held_rt_idx, ip_wb_we, ip_wb_addr, ip_wb_data);

        rd1_new = '0;
        if (rs_idx != '0)
            rd1_new = rs_m[XLEN] ? rs_m[XLEN-1:0] : regs[rs_idx];
        rd2_new = '0;
        if (rt_idx != '0)
            rd2_new = rt_m[XLEN] ? rt_m[XLEN-1:0] : regs[rt_idx];
    end

    // Logical immediates zero-extend, LUI shifts, everything else sign-extends.
    always_comb begin
        imm_w = {{48{imm16[15]}}, imm16};
        case (opcode)
            6'h0C, 6'h0D, 6'h0E: imm_w = {48'b0, imm16};
            6'h0F:               imm_w = {32'b0, imm16, 16'b0};
            default:             imm_w = {{48{imm16[15]}}, imm16};
        endcase
        imm_ext = imm_w[XLEN-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= XLEN'(i);
        end else begin
            for (int k = 0; k < WB_PORTS; k++) begin
                if (ip_wb_we[k] && ip_wb_addr[5*k +: IW] != '0)
                    regs[ip_wb_addr[5*k +: IW]] <= ip_wb_data[XLEN*k +: XLEN];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_valid           <= 1'b0;
            op_opcode          <= '0;
            op_function_opcode <= '0;
            op_PC_plus_4       <= '0;
            op_read_data_1     <= '0;
            op_read_data_2     <= '0;
            op_immediate       <= '0;
            op_dest_reg_R_type <= '0;
            op_dest_reg_I_type <= '0;
            op_dec_rs          <= '0;
            op_dec_rt          <= '0;
        end else if (ip_flush || (ip_stall && !ip_hold)) begin
            op_valid           <= 1'b0;
            op_opcode          <= '0;
            op_function_opcode <= '0;
            op_PC_plus_4       <= '0;
            op_read_data_1     <= '0;
            op_read_data_2     <= '0;
            op_immediate       <= '0;
            op_dest_reg_R_type <= '0;
            op_dest_reg_I_type <= '0;
            op_dec_rs          <= '0;
            op_dec_rt          <= '0;
        end else if (ip_hold) begin
            // Held operands must not go stale while write-back keeps retiring.
            if (held_rs_m[XLEN])
                op_read_data_1 <= held_rs_m[XLEN-1:0];
            if (held_rt_m[XLEN])
                op_read_data_2 <= held_rt_m[XLEN-1:0];
        end else begin
            op_valid           <= ip_valid;
            op_opcode          <= opcode;
            op_function_opcode <= ip_instruction[5:0];
            op_PC_plus_4       <= ip_PC_plus_4;
            op_read_data_1     <= rd1_new;
            op_read_data_2     <= rd2_new;
            op_immediate       <= imm_ext;
            op_dest_reg_R_type <= ip_valid ? ip_instruction[15:11] : 5'd0;
            op_dest_reg_I_type <= ip_valid ? ip_instruction[20:16] : 5'd0;
            op_dec_rs          <= ip_instruction[25:21];
            op_dec_rt          <= ip_instruction[20:16];
        end
    end

endmodule

// File: tb/tb_id_stage_param.sv
// tb/tb_id_stage_param.sv - directed self-checking bench for id_stage_param
module tb_id_stage_param;

    localparam int XLEN = 32;
    localparam int PCW  = 10;
    localparam int WBP  = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      ip_instruction = '0;
    logic [PCW-1:0]   ip_PC_plus_4 = '0;
    logic             ip_valid = 1'b0;
    logic             ip_stall = 1'b0;
    logic             ip_hold = 1'b0;
    logic             ip_flush = 1'b0;
    logic [WBP-1:0]   ip_wb_we = '0;
    logic [5*WBP-1:0] ip_wb_addr = '0;
    logic [XLEN*WBP-1:0] ip_wb_data = '0;
    logic             op_valid;
    logic [5:0]       op_opcode, op_function_opcode;
    logic [PCW-1:0]   op_PC_plus_4;
    logic [XLEN-1:0]  op_read_data_1, op_read_data_2, op_immediate;
    logic [4:0]       op_dest_reg_R_type, op_dest_reg_I_type, op_dec_rs, op_dec_rt;

    int checks = 0;
    int errors = 0;

    id_stage_param #(.XLEN(XLEN), .NREGS(32), .PCW(PCW), .WB_PORTS(WBP)) dut (
        .clock(clock), .reset(reset),
        .ip_instruction(ip_instruction), .ip_PC_plus_4(ip_PC_plus_4),
        .ip_valid(ip_valid), .ip_stall(ip_stall), .ip_hold(ip_hold), .ip_flush(ip_flush),
        .ip_wb_we(ip_wb_we), .ip_wb_addr(ip_wb_addr), .ip_wb_data(ip_wb_data),
        .op_valid(op_valid), .op_opcode(op_opcode), .op_function_opcode(op_function_opcode),
        .op_PC_plus_4(op_PC_plus_4), .op_read_data_1(op_read_data_1),
        .op_read_data_2(op_read_data_2), .op_immediate(op_immediate),
        .op_dest_reg_R_type(op_dest_reg_R_type), .op_dest_reg_I_type(op_dest_reg_I_type),
        .op_dec_rs(op_dec_rs), .op_dec_rt(op_dec_rt)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic valid);
        ip_instruction = instr;
        ip_valid       = valid;
        ip_PC_plus_4   = 10'h044;
        ip_wb_we       = '0;
        ip_wb_addr     = '0;
        ip_wb_data     = '0;
    endtask

    task automatic test_reset();
        drive(32'h00430820, 1'b1);
        ip_wb_we = 2'b01; ip_wb_addr = {5'd0, 5'd7}; ip_wb_data = {32'h0, 32'h1234};
        cyc();
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", op_valid); end
        checks++; if (op_read_data_1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h exp 0", op_read_data_1); end
        checks++; if (op_dest_reg_R_type !== 5'd0) begin errors++; $display("FAIL reset_destR got %0d exp 0", op_dest_reg_R_type); end
        checks++; if (op_PC_plus_4 !== 10'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", op_PC_plus_4); end
        drive(32'h0, 1'b0);
        reset = 1'b1;
        // write to reg 7 during reset must have been ignored
        drive(32'h00E70000, 1'b1);
        cyc();
        checks++; if (op_read_data_1 !== 32'h7) begin errors++; $display("FAIL reset_wb_ignored got %h exp 7", op_read_data_1); end
    endtask

    task automatic test_add();
        drive(32'h00430820, 1'b1);
        cyc();
        checks++; if (op_read_data_1 !== 32'h2) begin errors++; $display("FAIL add_rd1 got %h exp 2", op_read_data_1); end
        checks++; if (op_read_data_2 !== 32'h3) begin errors++; $display("FAIL add_rd2 got %h exp 3", op_read_data_2); end
        checks++; if (op_dest_reg_R_type !== 5'd1) begin errors++; $display("FAIL add_destR got %0d exp 1", op_dest_reg_R_type); end
        checks++; if (op_dest_reg_I_type !== 5'd3) begin errors++; $display("FAIL add_destI got %0d exp 3", op_dest_reg_I_type); end
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b exp 1", op_valid); end
        checks++; if (op_function_opcode !== 6'h20) begin errors++; $display("FAIL add_funct got %h exp 20", op_function_opcode); end
        checks++; if (op_PC_plus_4 !== 10'h044) begin errors++; $display("FAIL add_pc got %h exp 044", op_PC_plus_4); end
        checks++; if (op_immediate !== 32'h00000820) begin errors++; $display("FAIL add_imm got %h exp 00000820", op_immediate); end
    endtask

    task automatic test_bypass();
        drive(32'h00430820, 1'b1);
        ip_wb_we = 2'b01; ip_wb_addr = {5'd0, 5'd2}; ip_wb_data = {32'h0, 32'h55};
        cyc();
        checks++; if (op_read_data_1 !== 32'h55) begin errors++; $display("FAIL bypass_rd1 got %h exp 55", op_read_data_1); end
        drive(32'h00430820, 1'b1);
        cyc();
        checks++; if (op_read_data_1 !== 32'h55) begin errors++; $display("FAIL written_rd1 got %h exp 55", op_read_data_1); end
        drive(32'h00030820, 1'b1);
        ip_wb_we = 2'b01; ip_wb_addr = {5'd0, 5'd0}; ip_wb_data = {32'h0, 32'h77};
        cyc();
        checks++; if (op_read_data_1 !== 32'h0) begin errors++; $display("FAIL reg0_bypass got %h exp 0", op_read_data_1); end
        drive(32'h00030820, 1'b1);
        cyc();
        checks++; if (op_read_data_1 !== 32'h0) begin errors++; $display("FAIL reg0_write got %h exp 0", op_read_data_1); end
    endtask

    task automatic test_immediates();
        drive(32'h34008001, 1'b1); cyc();
        checks++; if (op_immediate !== 32'h00008001) begin errors++; $display("FAIL ori_imm got %h exp 00008001", op_immediate); end
        drive(32'h20008001, 1'b1); cyc();
        checks++; if (op_immediate !== 32'hFFFF8001) begin errors++; $display("FAIL addi_imm got %h exp FFFF8001", op_immediate); end
        drive(32'h3C001234, 1'b1); cyc();
        checks++; if (op_immediate !== 32'h12340000) begin errors++; $display("FAIL lui_imm got %h exp 12340000", op_immediate); end
        drive(32'h3000FFFF, 1'b1); cyc();
        checks++; if (op_immediate !== 32'h0000FFFF) begin errors++; $display("FAIL andi_imm got %h exp 0000FFFF", op_immediate); end
        checks++; if (op_opcode !== 6'h0C) begin errors++; $display("FAIL andi_opcode got %h exp 0C", op_opcode); end
    endtask

    task automatic test_hold_flush();
        drive(32'h00430820, 1'b1); cyc();
        ip_hold = 1'b1;
        drive(32'h00A50000, 1'b1);
        ip_PC_plus_4 = 10'h3FF;
        ip_wb_we = 2'b01; ip_wb_addr = {5'd0, 5'd2}; ip_wb_data = {32'h0, 32'h99};
        cyc();
        checks++; if (op_read_data_1 !== 32'h99) begin errors++; $display("FAIL hold_rd1 got %h exp 99", op_read_data_1); end
        checks++; if (op_read_data_2 !== 32'h3) begin errors++; $display("FAIL hold_rd2 got %h exp 3", op_read_data_2); end
        checks++; if (op_dest_reg_R_type !== 5'd1) begin errors++; $display("FAIL hold_destR got %0d exp 1", op_dest_reg_R_type); end
        checks++; if (op_PC_plus_4 !== 10'h044) begin errors++; $display("FAIL hold_pc got %h exp 044", op_PC_plus_4); end
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %0b exp 1", op_valid); end
        drive(32'h00A50000, 1'b1);
        ip_flush = 1'b1;
        cyc();
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", op_valid); end
        checks++; if (op_read_data_1 !== 32'h0) begin errors++; $display("FAIL flush_rd1 got %h exp 0", op_read_data_1); end
        checks++; if (op_dest_reg_R_type !== 5'd0) begin errors++; $display("FAIL flush_destR got %0d exp 0", op_dest_reg_R_type); end
        ip_hold = 1'b0; ip_flush = 1'b0;
    endtask

    task automatic test_stall_invalid();
        drive(32'h00430820, 1'b1);
        ip_stall = 1'b1;
        ip_wb_we = 2'b01; ip_wb_addr = {5'd0, 5'd3}; ip_wb_data = {32'h0, 32'h33};
        cyc();
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL stall_valid got %0b exp 0", op_valid); end
        checks++; if (op_dest_reg_R_type !== 5'd0) begin errors++; $display("FAIL stall_destR got %0d exp 0", op_dest_reg_R_type); end
        checks++; if (op_dest_reg_I_type !== 5'd0) begin errors++; $display("FAIL stall_destI got %0d exp 0", op_dest_reg_I_type); end
        ip_stall = 1'b0;
        drive(32'h00430820, 1'b0);
        cyc();
        checks++; if (op_read_data_2 !== 32'h33) begin errors++; $display("FAIL stall_wb_rd2 got %h exp 33", op_read_data_2); end
        checks++; if (op_dest_reg_R_type !== 5'd0) begin errors++; $display("FAIL inv_destR got %0d exp 0", op_dest_reg_R_type); end
        checks++; if (op_dest_reg_I_type !== 5'd0) begin errors++; $display("FAIL inv_destI got %0d exp 0", op_dest_reg_I_type); end
        checks++; if (op_function_opcode !== 6'h20) begin errors++; $display("FAIL inv_funct got %h exp 20", op_function_opcode); end
    endtask

    task automatic test_dual_port();
        drive(32'h00A50000, 1'b1);
        ip_wb_we = 2'b11; ip_wb_addr = {5'd5, 5'd5}; ip_wb_data = {32'hB, 32'hA};
        cyc();
        checks++; if (op_read_data_1 !== 32'hB) begin errors++; $display("FAIL dual_bypass_rd1 got %h exp B", op_read_data_1); end
        checks++; if (op_read_data_2 !== 32'hB) begin errors++; $display("FAIL dual_bypass_rd2 got %h exp B", op_read_data_2); end
        drive(32'h00A50000, 1'b1);
        cyc();
        checks++; if (op_read_data_1 !== 32'hB) begin errors++; $display("FAIL dual_write_rd1 got %h exp B", op_read_data_1); end
    endtask

    task automatic test_async_reset();
        drive(32'h00430820, 1'b1); cyc();
        #2 reset = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b exp 0", op_valid); end
        checks++; if (op_read_data_1 !== 32'h0) begin errors++; $display("FAIL areset_rd1 got %h exp 0", op_read_data_1); end
        checks++; if (op_dest_reg_I_type !== 5'd0) begin errors++; $display("FAIL areset_destI got %0d exp 0", op_dest_reg_I_type); end
        cyc();
        reset = 1'b1;
        drive(32'h00430820, 1'b1); cyc();
        checks++; if (op_read_data_1 !== 32'h2) begin errors++; $display("FAIL areset_reg2 got %h exp 2", op_read_data_1); end
        checks++; if (op_read_data_2 !== 32'h3) begin errors++; $display("FAIL areset_reg3 got %h exp 3", op_read_data_2); end
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL areset_first_load got %0b exp 1", op_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_bypass();
        test_immediates();
        test_hold_flush();
        test_stall_invalid();
        test_dual_port();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
